// File: rtl/bram_stream_reader_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bram_stream_reader_pkg
// Description : Shared types and constants for the block-ram stream reader.
// Revision    : 1.0 - initial release
// ============================================================================
package bram_stream_reader_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    localparam int BUFFER_DEPTH = 2;

endpackage
`default_nettype wire

// File: rtl/stream_skid_buffer.sv
`default_nettype none
// ============================================================================
// Module      : stream_skid_buffer
// Description : Two-entry FIFO with a registered head; the head drives the
//               stream outputs directly and holds steady while stalled.
// Revision    : 1.0 - initial release
// ============================================================================
module stream_skid_buffer #(
    parameter int Width = 9
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    input  logic [Width-1:0] in_data,
    output logic             out_valid,
    output logic [Width-1:0] out_data,
    input  logic             out_ready,
    output logic [1:0]       count
);

    logic [Width-1:0] head;
    logic [Width-1:0] tail;
    logic [1:0]       fill;
    logic             pop;

    assign out_valid = (fill != 2'd0);
    assign out_data  = head;
    assign count     = fill;
    assign pop       = out_valid & out_ready;

    // Push into a full buffer is prevented upstream by read credit accounting.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head <= '0;
            tail <= '0;
            fill <= 2'd0;
        end else if (flush) begin
            fill <= 2'd0;
        end else begin
            case ({in_valid, pop})
                2'b10: begin
                    if (fill == 2'd0) head <= in_data;
                    else              tail <= in_data;
                    fill <= fill + 2'd1;
                end
                2'b01: begin
                    head <= tail;
                    fill <= fill - 2'd1;
                end
                2'b11: begin
                    if (fill == 2'd1) begin
                        head <= in_data;
                    end else begin
                        head <= tail;
                        tail <= in_data;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/bram_stream_reader.sv
`default_nettype none
// ============================================================================
// Module      : bram_stream_reader
// Description : Bursts words out of a 1-cycle-latency block ram onto a
//               valid/ready stream. Define BRAM_STREAM_READER_LOOP_EN to add
//               the loop input for repeating bursts.
// Revision    : 1.0 - initial release
// ============================================================================
module bram_stream_reader
    import bram_stream_reader_pkg::*;
#(
    parameter int WordLengthBits   = 8,
    parameter int NumWords         = 128,
    parameter int AddressWidthBits = 7
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start,
    input  logic [AddressWidthBits-1:0] start_address,
    input  logic [AddressWidthBits:0]   length,
    input  logic                        abort,
`ifdef BRAM_STREAM_READER_LOOP_EN
    input  logic                        loop,
`endif
    output logic [AddressWidthBits-1:0] bram_address,
    input  logic [WordLengthBits-1:0]   bram_data,
    output logic [WordLengthBits-1:0]   out_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic                        out_last,
    output logic                        busy,
    output logic                        done
);

    localparam logic [AddressWidthBits-1:0] LAST_ADDRESS = AddressWidthBits'(NumWords - 1);
    localparam logic [AddressWidthBits:0]   ONE_WORD     = (AddressWidthBits+1)'(1);

    state_t                        state;
    logic [AddressWidthBits:0]     remaining;
    logic                          pending;
    logic                          pending_last;
    logic                          done_zero;
    logic [1:0]                    buf_count;
    logic [WordLengthBits:0]       head;
    logic                          pop;
    logic                          issue;
    logic                          final_pop;
    logic                          flush;
    logic [2:0]                    credit_used;
    logic [AddressWidthBits-1:0]   next_address;
`ifdef BRAM_STREAM_READER_LOOP_EN
    logic [AddressWidthBits-1:0]   loop_address;
    logic [AddressWidthBits:0]     loop_length;
`endif

    assign pop          = out_valid & out_ready;
    assign flush        = abort & (state != ST_IDLE);
    // The word in the ram pipeline plus buffered words, minus the one leaving now.
    assign credit_used  = 3'(pending) + 3'(buf_count) - 3'(pop);
    assign issue        = (state == ST_READ) && (credit_used < 3'(BUFFER_DEPTH));
    assign next_address = (bram_address == LAST_ADDRESS) ? '0 : bram_address + 1'b1;
    assign final_pop    = (state == ST_DRAIN) && pop && (buf_count == 2'd1) && !pending;
    assign busy         = (state != ST_IDLE);
    assign done         = done_zero | (final_pop & ~abort);
    assign out_data     = head[WordLengthBits-1:0];
    assign out_last     = out_valid & head[WordLengthBits];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            remaining    <= '0;
            pending      <= 1'b0;
            pending_last <= 1'b0;
            done_zero    <= 1'b0;
            bram_address <= '0;
`ifdef BRAM_STREAM_READER_LOOP_EN
            loop_address <= '0;
            loop_length  <= '0;
`endif
        end else begin
            done_zero <= 1'b0;
            pending   <= 1'b0;
            if (flush) begin
                state <= ST_IDLE;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (start && !abort) begin
                            if (length != '0) begin
                                bram_address <= start_address;
                                remaining    <= length;
                                state        <= ST_READ;
`ifdef BRAM_STREAM_READER_LOOP_EN
                                loop_address <= start_address;
                                loop_length  <= length;
`endif
                            end else begin
                                done_zero <= 1'b1;
                            end
                        end
                    end
                    ST_READ: begin
                        if (issue) begin
                            pending      <= 1'b1;
                            pending_last <= (remaining == ONE_WORD);
                            if (remaining == ONE_WORD) begin
`ifdef BRAM_STREAM_READER_LOOP_EN
                                if (loop) begin
                                    bram_address <= loop_address;
                                    remaining    <= loop_length;
                                end else begin
                                    bram_address <= next_address;
                                    state        <= ST_DRAIN;
                                end
`else
                                bram_address <= next_address;
                                state        <= ST_DRAIN;
`endif
                            end else begin
                                bram_address <= next_address;
                                remaining    <= remaining - ONE_WORD;
                            end
                        end
                    end
                    ST_DRAIN: begin
                        if (final_pop) state <= ST_IDLE;
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

    stream_skid_buffer #(
        .Width (WordLengthBits + 1)
    ) u_buffer (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (pending),
        .in_data   ({pending_last, bram_data}),
        .out_valid (out_valid),
        .out_data  (head),
        .out_ready (out_ready),
        .count     (buf_count)
    );

endmodule
`default_nettype wire

// File: tb/tb_bram_stream_reader.sv
`default_nettype none
// ============================================================================
// Module      : tb_bram_stream_reader
// Description : Scoreboard bench; stimulus queues expected words, a negedge
//               monitor pops and compares every transfer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bram_stream_reader;

    typedef struct packed {
        logic [7:0] data;
        logic       last;
        logic       fin;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [6:0] start_address;
    logic [7:0] length;
    logic       abort;
    logic       loop_in;
    logic [6:0] bram_address;
    logic [7:0] bram_data;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic       out_last;
    logic       busy;
    logic       done;

    logic [7:0] ram [0:127];
    exp_t       sb [$];
    int         n_checks = 0;
    int         n_fail   = 0;
    int         xfer_count = 0;
    int         ready_mode = 0;
    int         pat_idx = 0;
    logic       pat [4];
    logic       zero_len_window = 1'b0;
    logic       holding = 1'b0;
    logic [8:0] held;

    always #5 clk = ~clk;

    bram_stream_reader dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .start_address (start_address),
        .length        (length),
        .abort         (abort),
`ifdef BRAM_STREAM_READER_LOOP_EN
        .loop          (loop_in),
`endif
        .bram_address  (bram_address),
        .bram_data     (bram_data),
        .out_data      (out_data),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_last      (out_last),
        .busy          (busy),
        .done          (done)
    );

    // Read-first synchronous ram with one cycle of latency.
    always @(posedge clk) bram_data <= ram[bram_address];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    initial begin
        pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1;
        out_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0: out_ready = 1'b1;
                1: out_ready = 1'($urandom_range(0, 1));
                default: begin
                    out_ready = (pat_idx < 4) ? pat[pat_idx] : 1'($urandom_range(0, 1));
                    if (out_valid) pat_idx++;
                end
            endcase
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            holding = 1'b0;
        end else begin
            if (out_valid) begin
                if (holding) check("stall_stable", {23'd0, out_last, out_data}, {23'd0, held});
                if (out_ready) begin
                    xfer_count++;
                    if (sb.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_word: got %0h expected none", out_data);
                    end else begin
                        e = sb.pop_front();
                        check("word_data", 32'(out_data), 32'(e.data));
                        check("word_last", 32'(out_last), 32'(e.last));
                        check("done_on_transfer", 32'(done), 32'(e.last && e.fin && !abort));
                    end
                    holding = 1'b0;
                end else begin
                    held    = {out_last, out_data};
                    holding = 1'b1;
                end
            end else begin
                holding = 1'b0;
                if (!zero_len_window) check("done_idle", 32'(done), 32'd0);
            end
            if (abort && busy) begin
                sb.delete();
                holding = 1'b0;
            end
        end
    end

    task automatic push_burst(input int sa, input int len, input int passes);
        exp_t e;
        for (int p = 0; p < passes; p++) begin
            for (int i = 0; i < len; i++) begin
                e.data = ram[(sa + i) % 128];
                e.last = (i == len - 1);
                e.fin  = (i == len - 1) && (p == passes - 1);
                sb.push_back(e);
            end
        end
    endtask

    task automatic start_burst(input int sa, input int len);
        push_burst(sa, len, 1);
        start         = 1'b1;
        start_address = 7'(sa);
        length        = 8'(len);
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_idle();
        int k;
        for (k = 0; k < 600; k++) begin
            @(negedge clk);
            if (!busy && sb.size() == 0) break;
        end
        if (k == 600) check("wait_idle_timeout", 32'(busy), 32'd0);
    endtask

    task automatic timing_check(input int exp_run);
        int first = -1;
        int run = 0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (out_valid) begin
                if (first < 0) first = k;
                if (run == k - first) run++;
            end
        end
        check("first_valid_edge", 32'(first), 32'd2);
        if (exp_run > 0) check("burst_run", 32'(run), 32'(exp_run));
    endtask

    initial begin
        int base;
        for (int i = 0; i < 128; i++) ram[i] = 8'((i * 37 + 5) & 8'hff);
        for (int i = 0; i < 8; i++) ram[i] = 8'(8'h10 + i);
        start = 1'b0; start_address = '0; length = '0; abort = 1'b0; loop_in = 1'b0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #2;
        check("rst_bram_address", 32'(bram_address), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_last", 32'(out_last), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Eight consecutive words, last and done on 0x17
        ready_mode = 0;
        start_burst(0, 8);
        timing_check(8);
        wait_idle();

        // Address wrap around the top of the ram
        start_burst(126, 4);
        wait_idle();

        // Stall pattern then random back-pressure
        pat_idx = 0;
        ready_mode = 2;
        start_burst(9, 6);
        wait_idle();

        // Zero-length request
        ready_mode = 0;
        zero_len_window = 1'b1;
        start = 1'b1; start_address = 7'd3; length = 8'd0;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        check("zero_len_done", 32'(done), 32'd1);
        check("zero_len_busy", 32'(busy), 32'd0);
        check("zero_len_valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        check("zero_len_done_gone", 32'(done), 32'd0);
        check("zero_len_busy2", 32'(busy), 32'd0);
        zero_len_window = 1'b0;

        // Abort after three transfers of a ten-word burst
        base = xfer_count;
        start_burst(50, 10);
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (xfer_count >= base + 3) break;
        end
        check("abort_reached_three", 32'(xfer_count - base), 32'd3);
        @(posedge clk);
        #1 abort = 1'b1;
        @(posedge clk);
        #1 abort = 1'b0;
        @(negedge clk);
        check("abort_valid_low", 32'(out_valid), 32'd0);
        check("abort_busy_low", 32'(busy), 32'd0);
        check("abort_no_done", 32'(done), 32'd0);
        repeat (3) begin
            @(negedge clk);
            check("abort_quiet", 32'(out_valid), 32'd0);
        end
        @(posedge clk);
        #1;
        start_burst(20, 5);
        wait_idle();

        // Random bursts under random back-pressure
        ready_mode = 1;
        for (int t = 0; t < 8; t++) begin
            @(posedge clk);
            #1;
            start_burst(int'($urandom_range(0, 127)), int'($urandom_range(1, 16)));
            wait_idle();
        end

        // Asynchronous reset in the middle of a burst
        ready_mode = 0;
        @(posedge clk);
        #1;
        start_burst(40, 20);
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_bram_address", 32'(bram_address), 32'd0);
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_out_last", 32'(out_last), 32'd0);
        check("midrst_out_data", 32'(out_data), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_done", 32'(done), 32'd0);
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        start_burst(2, 3);
        timing_check(3);
        wait_idle();

`ifdef BRAM_STREAM_READER_LOOP_EN
        // Repeating two-word pattern, three passes before loop drops
        @(posedge clk);
        #1;
        loop_in = 1'b1;
        push_burst(4, 2, 3);
        start = 1'b1; start_address = 7'd4; length = 8'd2;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (4) @(posedge clk);
        #1 loop_in = 1'b0;
        wait_idle();
`endif

        repeat (3) @(negedge clk);
        check("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/bram_stream_reader.md
BRAM_STREAM_READER -- requirements
Module: bram_stream_reader

Interface
REQ-001 SHALL have parameter WordLengthBits, default 8, bits per stored word.
REQ-002 SHALL have parameter NumWords, default 128, depth of the attached block ram.
REQ-003 SHALL have parameter AddressWidthBits, default 7, width of the ram address.
REQ-004 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port start  input  1  one-cycle request to begin a burst.
REQ-007 SHALL have port start_address  input  AddressWidthBits  first word address, sampled with start.
REQ-008 SHALL have port length  input  AddressWidthBits+1  words in burst, sampled with start.
REQ-009 SHALL have port abort  input  1  cancel the current burst.
REQ-010 SHALL have port bram_address  output  AddressWidthBits  read address to the ram read port.
REQ-011 SHALL have port bram_data  input  WordLengthBits  ram read data, valid one cycle after the address.
REQ-012 SHALL have port out_data  output  WordLengthBits  stream data.
REQ-013 SHALL have port out_valid  output  1  out_data holds a word.
REQ-014 SHALL have port out_ready  input  1  sink accepts; transfer when out_valid && out_ready.
REQ-015 SHALL have port out_last  output  1  high with the final word of the burst.
REQ-016 SHALL have ports busy  output  1  burst in progress; done  output  1  one-cycle completion pulse.

Function
REQ-017 SHALL implement FSM IDLE, READ, DRAIN; busy high whenever state != IDLE.
REQ-018 IDLE: start with length != 0 SHALL load bram_address = start_address, move to READ, and count that address as the first read issued.
REQ-019 IDLE: start with length == 0 SHALL stay IDLE, produce no words, and pulse done on the next cycle.
REQ-020 start while busy SHALL be ignored.
REQ-021 Each read SHALL be issued only if in-flight reads plus buffered words < 2, using a 2-entry output buffer.
REQ-022 bram_address SHALL increment by one per issued read, wrapping from NumWords-1 to 0.
REQ-023 With out_ready held high, SHALL sustain one transfer per cycle; the first out_valid SHALL rise two rising edges after the edge that samples start.
REQ-024 Words SHALL emerge in address order, without loss or duplication, under any out_ready pattern.
REQ-025 out_valid/out_data/out_last SHALL remain stable while out_valid && !out_ready.
REQ-026 READ -> DRAIN when the length-th read is issued; DRAIN -> IDLE on the cycle the last word transfers, with done pulsed on that same cycle.
REQ-027 abort in any busy state SHALL, on the next edge, return to IDLE, flush buffer and in-flight data, and force out_valid low; done SHALL NOT pulse; abort has priority over start.
REQ-028 A transfer coincident with abort SHALL count as completed; no further words follow.

Reset
REQ-029 rst_n low SHALL immediately clear state to IDLE, empty the buffer, and set busy, done, out_valid, out_last, out_data and bram_address to 0.
REQ-030 The first start SHALL be honoured on the first rising edge after rst_n deasserts.

Configuration
REQ-031 With macro BRAM_STREAM_READER_LOOP_EN defined, SHALL add input port loop (1 bit); if loop is high when the last read issues, reading SHALL continue from start_address, out_last SHALL still mark each pass, and done SHALL NOT pulse until a pass ends with loop low.
REQ-032 Without BRAM_STREAM_READER_LOOP_EN, the loop port SHALL be absent and behaviour SHALL be as if loop = 0.

Structure
REQ-033 SHALL place the FSM state enum typedef in package bram_stream_reader_pkg.
REQ-034 SHALL implement the 2-entry output buffer as sub-module stream_skid_buffer (parameter WordLengthBits+1, data plus last).
REQ-035 SHALL pair with bram_dual_port (read-first, 1-cycle latency) without glue logic.

Verification
REQ-036 Bench: ram[0..7] = 0x10..0x17, start_address 0, length 8, out_ready = 1 -> 0x10..0x17 on 8 consecutive cycles, out_last on 0x17, done on that cycle.
REQ-037 Bench: start_address 126, length 4, NumWords 128 -> addresses 126,127,0,1 in order; data matches ram.
REQ-038 Bench: length 6, out_ready toggling 1,0,0,1 with random stalls -> 6 words in order, stable during stalls, no duplicates.
REQ-039 Bench: length 0 -> no out_valid; done one cycle later; busy stays 0.
REQ-040 Bench: abort after 3 transfers of a 10-word burst -> out_valid low next cycle, no done, a new start then reads correctly.
REQ-041 Bench: rst_n low mid-burst -> all outputs 0 asynchronously; with LOOP_EN, loop = 1 and length 2 -> repeating 2-word pattern until loop drops.
